// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the FSM state encoding, the EX operand-source select encoding,
// counter widths and small compare/increment helpers.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  localparam int unsigned STALL_CNT_W = 32;
  localparam int unsigned WAIT_CNT_W  = 16;
  localparam int unsigned REG_IDX_W   = 5;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    logic [STALL_CNT_W-1:0] r;
    if (v == {STALL_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // A source/destination pair hazards only when the source is really read,
  // the destination is really written, and the index is not x0.
  function automatic logic idx_hit(input logic                 src_used,
                                   input logic [REG_IDX_W-1:0] src,
                                   input logic                 dst_written,
                                   input logic [REG_IDX_W-1:0] dst);
    return src_used && dst_written && (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Pure combinational EX-operand forwarding select.
// EX/MEM result has priority over MEM/WB; x0 is never forwarded.
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_ex_rs1,
  input  logic [4:0] id_ex_rs2,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_reg_write,
  input  logic [4:0] mem_wb_rd,
  input  logic       mem_wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  function automatic fwd_sel_e pick(input logic [4:0] src);
    fwd_sel_e r;
    if (idx_hit(1'b1, src, ex_mem_reg_write, ex_mem_rd)) begin
      r = FWD_EXMEM;
    end else if (idx_hit(1'b1, src, mem_wb_reg_write, mem_wb_rd)) begin
      r = FWD_MEMWB;
    end else begin
      r = FWD_RF;
    end
    return r;
  endfunction

  // Select operand sources for both EX inputs.
  always_comb begin
    fwd_a = pick(id_ex_rs1);
    fwd_b = pick(id_ex_rs2);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stalls, redirect flushes,
// data-memory wait with timeout, forwarding select and a stall counter.
// Optional macro HAZARD_CTRL_FWD_EN enables operand forwarding; without it
// RAW hazards on EX/MEM-stage producers are resolved by stalling.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAX_MEM_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        if_id_use_rs1,
  input  logic        if_id_use_rs2,
  input  logic [4:0]  id_ex_rs1,
  input  logic [4:0]  id_ex_rs2,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_reg_write,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_reg_write,
  input  logic [4:0]  mem_wb_rd,
  input  logic        mem_wb_reg_write,
  input  logic        ex_redirect,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  // Last counter value before the wait is declared timed out.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_MEM_WAIT - 1);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       bubble_s;
  logic       hold_all_s;
  logic       eval_hz_s;
  logic [1:0] fwd_a_s, fwd_b_s;

`ifdef HAZARD_CTRL_FWD_EN
  hazard_fwd_unit u_fwd (
    .id_ex_rs1        (id_ex_rs1),
    .id_ex_rs2        (id_ex_rs2),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .fwd_a            (fwd_a_s),
    .fwd_b            (fwd_b_s)
  );
`else
  // Without forwarding these inputs carry no information for this block.
  logic unused_fwd_inputs_s;
  assign unused_fwd_inputs_s = ^{id_ex_rs1, id_ex_rs2, mem_wb_rd, mem_wb_reg_write};
  assign fwd_a_s = FWD_RF;
  assign fwd_b_s = FWD_RF;
`endif

  // Detect an ID-stage source that must wait one more cycle for its producer.
  always_comb begin
    bubble_s = idx_hit(if_id_use_rs1, if_id_rs1, id_ex_mem_read, id_ex_rd) ||
               idx_hit(if_id_use_rs2, if_id_rs2, id_ex_mem_read, id_ex_rd);
`ifndef HAZARD_CTRL_FWD_EN
    // MEM/WB producers are covered by regfile write-through.
    bubble_s = bubble_s ||
               idx_hit(if_id_use_rs1, if_id_rs1, id_ex_reg_write,  id_ex_rd)  ||
               idx_hit(if_id_use_rs2, if_id_rs2, id_ex_reg_write,  id_ex_rd)  ||
               idx_hit(if_id_use_rs1, if_id_rs1, ex_mem_reg_write, ex_mem_rd) ||
               idx_hit(if_id_use_rs2, if_id_rs2, ex_mem_reg_write, ex_mem_rd);
`endif
  end

  // Decide whether the whole pipe is frozen or normal hazard rules apply.
  always_comb begin
    hold_all_s = 1'b0;
    eval_hz_s  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          hold_all_s = 1'b1;
        end else begin
          eval_hz_s = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          hold_all_s = 1'b1;
        end else begin
          eval_hz_s = 1'b1;
        end
      end
      ST_ERROR: hold_all_s = 1'b1;
      default:  hold_all_s = 1'b1;
    endcase
  end

  // Drive stall/flush/forward outputs; reset overrides everything combinationally.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;
    mem_err      = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      fwd_a   = fwd_a_s;
      fwd_b   = fwd_b_s;
      mem_err = (state_q == ST_ERROR);
      if (hold_all_s) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end else if (eval_hz_s && ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (eval_hz_s && bubble_s) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_stall = 1'b0;
      end
    end
  end

  // Next-state, wait-timeout and stall-count computation.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = {WAIT_CNT_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
    if (pc_stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Controller state and counters; reset abandons any pending wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= {WAIT_CNT_W{1'b0}};
      stall_cnt_q <= {STALL_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MAX_MEM_WAIT, default 255: data-memory wait cycles allowed before timeout (1..65535).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 if_id_use_rs1, if_id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-006 id_ex_rs1, id_ex_rs2, id_ex_rd  in  5 each  EX-stage register indices.
REQ-007 id_ex_mem_read, id_ex_reg_write  in  1 each  EX-stage load / register-write flags.
REQ-008 ex_mem_rd, mem_wb_rd  in  5 each; ex_mem_reg_write, mem_wb_reg_write  in  1 each  later-stage writeback info.
REQ-009 ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
REQ-010 dmem_req  in  1  MEM stage issues a data access; dmem_ready  in  1  access completes this cycle.
REQ-011 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the corresponding register.
REQ-012 if_id_flush, id_ex_flush  out  1 each  load a bubble into the corresponding register.
REQ-013 fwd_a, fwd_b  out  2 each  EX operand source select: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-014 mem_err  out  1  sticky data-memory timeout flag; stall_cycles  out  32  count of stalled cycles.

Function
REQ-015 FSM states RUN, MEM_WAIT, ERROR; encoding free, reset state RUN.
REQ-016 Load-use: in RUN, id_ex_mem_read=1, id_ex_rd!=0 and id_ex_rd equals a used ID source -> pc_stall=if_id_stall=id_ex_flush=1 same cycle (one bubble, combinational, no extra state).
REQ-017 Redirect: in RUN, ex_redirect=1 -> if_id_flush=id_ex_flush=1, pc_stall=0; overrides a simultaneous load-use (no stall).
REQ-018 Memory wait: in RUN, dmem_req=1 and dmem_ready=0 -> all four stall outputs=1 that cycle, flushes=0, next state MEM_WAIT.
REQ-019 MEM_WAIT: all four stalls=1, flushes=0; dmem_ready=1 -> stalls=0 that cycle, RUN next; pending ex_redirect/load-use evaluated normally in that completing cycle.
REQ-020 Priority: rst > ERROR > memory wait > redirect > load-use.
REQ-021 Wait counter 16 bits, cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle; reaching MAX_MEM_WAIT with dmem_ready=0 -> ERROR next.
REQ-022 ERROR: all stalls=1, flushes=0, mem_err=1; exits only on rst.
REQ-023 stall_cycles increments by 1 each cycle pc_stall=1; saturates at 0xFFFF_FFFF, no wrap.
REQ-024 Register index 0 never causes a hazard or forward.

Reset
REQ-025 While rst=1 outputs override combinationally: stalls=0, flushes=1, fwd=00, mem_err=0.
REQ-026 On rst edge: state RUN, wait counter 0, stall_cycles 0, mem_err 0; reset mid-MEM_WAIT abandons the wait.

Configuration
REQ-027 Macro HAZARD_CTRL_FWD_EN defined: fwd_a/fwd_b select EX/MEM when ex_mem_reg_write and ex_mem_rd match id_ex_rs1/rs2, else MEM/WB on match, else 00; EX/MEM has priority.
REQ-028 Macro undefined: fwd_a=fwd_b=00 always; in RUN, a used ID source matching a writing id_ex_rd or ex_mem_rd (nonzero) stalls as REQ-016 each cycle until clear; MEM/WB covered by regfile write-through.

Structure
REQ-029 Shared package holds FSM state enum, fwd select enum (FWD_RF, FWD_EXMEM, FWD_MEMWB) and 32-bit saturating-counter width constant.
REQ-030 One sub-module hazard_fwd_unit (pure combinational compare/select) instantiated only under HAZARD_CTRL_FWD_EN; FSM and counters stay in hazard_ctrl.

Verification
REQ-031 Load x5 in EX (id_ex_rd=5, mem_read=1), ID uses rs1=5 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, then 0.
REQ-032 ex_redirect=1 with simultaneous load-use -> if_id_flush=id_ex_flush=1, pc_stall=0, stall_cycles unchanged.
REQ-033 dmem_req=1, dmem_ready low 3 cycles then high -> stalls=1 for 3 cycles, 0 on ready cycle, stall_cycles=3.
REQ-034 MAX_MEM_WAIT=4, dmem_ready never high -> ERROR after 5 stalled cycles, mem_err=1 until rst, then RUN and mem_err=0.
REQ-035 FWD_EN: ex_mem_rd=mem_wb_rd=id_ex_rs1=7, both writing -> fwd_a=01; id_ex_rs1=0 -> fwd_a=00; without macro the same ID-side match stalls.
REQ-036 rst asserted mid-MEM_WAIT -> flushes=1, stalls=0 during rst; after release state RUN, counters 0.
